regfile_writeback: RTL and testbench

// - Writer side of the register-file write port (wen/waddr/wdata): arbitrates ALU and LSU results into one registered write per cycle.
// - Keeps a per-register pending scoreboard so decode can stall on RAW hazards.
// - Sits between the execute/LSU result channels and the register file; decode marks destinations at issue.

---
 rtl/regfile_writeback.sv | 120 ++++++++++++
 tb/tb_regfile_writeback.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU and LSU results into one registered register-file write per
// cycle and keeps a RAW pending scoreboard for decode. Optional macro WB_BYPASS_EN adds a write-stage bypass.
module regfile_writeback #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_NUM     = 32,
  parameter int REG_NUM_BIT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_NUM_BIT-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]  alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [REG_NUM_BIT-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]  lsu_data,
  input  logic                   iss_valid,
  input  logic [REG_NUM_BIT-1:0] iss_rd,
  input  logic [REG_NUM_BIT-1:0] raddr_a,
  input  logic [REG_NUM_BIT-1:0] raddr_b,
  output logic                   busy_a,
  output logic                   busy_b,
  output logic                   fwd_a_valid,
  output logic                   fwd_b_valid,
  output logic [DATA_WIDTH-1:0]  fwd_a_data,
  output logic [DATA_WIDTH-1:0]  fwd_b_data,
  output logic                   rf_wen,
  output logic [REG_NUM_BIT-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata
);

  logic                   r_wen;
  logic [REG_NUM_BIT-1:0] r_waddr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic                   r_rr_lsu;  // 1: LSU wins the next contended cycle
  logic [REG_NUM-1:0]     r_pending;
  logic [REG_NUM-1:0]     w_pending_nxt;
  logic                   w_alu_grant;
  logic                   w_lsu_grant;
  logic                   w_accept;
  logic [REG_NUM_BIT-1:0] w_sel_rd;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic                   w_hit_a;
  logic                   w_hit_b;

  // Register 0 is never tracked; addresses beyond REG_NUM have no scoreboard bit.
  function automatic logic tracked(input logic [REG_NUM_BIT-1:0] addr);
    return (addr != '0) && (int'(addr) < REG_NUM);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    w_alu_grant = 1'b0;
    w_lsu_grant = 1'b0;
    if (!rst) begin
      if (alu_valid && lsu_valid) begin
        w_lsu_grant = r_rr_lsu;
        w_alu_grant = !r_rr_lsu;
      end else begin
        w_lsu_grant = lsu_valid;
        w_alu_grant = alu_valid;
      end
    end
  end

  assign alu_ready  = w_alu_grant;
  assign lsu_ready  = w_lsu_grant;
  assign w_accept   = w_alu_grant | w_lsu_grant;
  assign w_sel_rd   = w_lsu_grant ? lsu_rd : alu_rd;
  assign w_sel_data = w_lsu_grant ? lsu_data : alu_data;

  // Clear before set so a new producer issued alongside the retiring write keeps the bit.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_wen && tracked(r_waddr)) w_pending_nxt[r_waddr] = 1'b0;
    if (iss_valid && tracked(iss_rd)) w_pending_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (rst) begin
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_rr_lsu  <= 1'b1;
      r_pending <= '0;
    end else begin
      r_wen <= w_accept && (w_sel_rd != '0);
      if (w_accept) begin
        r_waddr <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
      if (alu_valid && lsu_valid) r_rr_lsu <= w_alu_grant;
      r_pending <= w_pending_nxt;
    end
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

`ifdef WB_BYPASS_EN
  assign w_hit_a    = r_wen && (r_waddr == raddr_a) && (raddr_a != '0);
  assign w_hit_b    = r_wen && (r_waddr == raddr_b) && (raddr_b != '0);
  assign fwd_a_data = r_wdata;
  assign fwd_b_data = r_wdata;
`else
  assign w_hit_a    = 1'b0;
  assign w_hit_b    = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_data = '0;
`endif

  assign fwd_a_valid = w_hit_a;
  assign fwd_b_valid = w_hit_b;
  assign busy_a      = tracked(raddr_a) && r_pending[raddr_a] && !w_hit_a;
  assign busy_b      = tracked(raddr_b) && r_pending[raddr_b] && !w_hit_b;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the writeback rules.
module tb_regfile_writeback;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int RB = 5;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready, lsu_valid, lsu_ready, iss_valid;
  logic [RB-1:0] alu_rd, lsu_rd, iss_rd, raddr_a, raddr_b, rf_waddr;
  logic [DW-1:0] alu_data, lsu_data, fwd_a_data, fwd_b_data, rf_wdata;
  logic          busy_a, busy_b, fwd_a_valid, fwd_b_valid, rf_wen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_writeback #(.DATA_WIDTH(DW), .REG_NUM(RN), .REG_NUM_BIT(RB)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .busy_a(busy_a), .busy_b(busy_b), .fwd_a_valid(fwd_a_valid), .fwd_b_valid(fwd_b_valid),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    iss_valid = 1'b0; iss_rd = '0; raddr_a = '0; raddr_b = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    raddr_a = 5'd3; raddr_b = 5'd4;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got %b exp 0", alu_ready); end
      checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready got %b exp 0", lsu_ready); end
      checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got %b exp 0", rf_wen); end
      checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b exp 00", busy_a, busy_b); end
    end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_raw_hazard();
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd5; raddr_a = 5'd5;
    @(negedge clk); iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; #1;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL raw_busy_issued got %b exp 1", busy_a); end
    checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL raw_ready got alu=%b lsu=%b exp 1/0", alu_ready, lsu_ready); end
    @(negedge clk); alu_valid = 1'b0; #1;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_write got wen=%b addr=%0d data=%h exp 1/5/deadbeef", rf_wen, rf_waddr, rf_wdata); end
    checks++; if (busy_a !== !BYP) begin errors++; $display("FAIL raw_busy_wb got %b exp %b", busy_a, !BYP); end
    @(negedge clk); #1;
    checks++; if (busy_a !== 1'b0 || rf_wen !== 1'b0) begin errors++; $display("FAIL raw_after got busy=%b wen=%b exp 0/0", busy_a, rf_wen); end
    idle();
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] ad, ld;
    ad = $urandom; ld = $urandom;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = ld;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = ad;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (lsu_ready !== (k % 2 == 0) || alu_ready !== (k % 2 == 1)) begin errors++; $display("FAIL rr_grant%0d got lsu=%b alu=%b exp lsu=%b", k, lsu_ready, alu_ready, k % 2 == 0); end
      if (k > 0) begin
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== (((k - 1) % 2 == 0) ? 5'd2 : 5'd1) || rf_wdata !== (((k - 1) % 2 == 0) ? ld : ad)) begin errors++; $display("FAIL rr_write%0d got wen=%b addr=%0d data=%h", k, rf_wen, rf_waddr, rf_wdata); end
      end
      @(negedge clk);
    end
    idle(); #1;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== ad) begin errors++; $display("FAIL rr_write4 got wen=%b addr=%0d data=%h exp 1/1/%h", rf_wen, rf_waddr, rf_wdata, ad); end
  endtask

  task automatic test_rd_zero();
    @(negedge clk); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234; raddr_a = 5'd0; #1;
    checks++; if (alu_ready !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL rd0_accept got ready=%b busy=%b exp 1/0", alu_ready, busy_a); end
    @(negedge clk); alu_valid = 1'b0; #1;
    checks++; if (rf_wen !== 1'b0 || busy_a !== 1'b0 || fwd_a_valid !== 1'b0) begin errors++; $display("FAIL rd0_nowrite got wen=%b busy=%b fwd=%b exp 0/0/0", rf_wen, busy_a, fwd_a_valid); end
    idle();
  endtask

  task automatic test_set_wins();
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd7; raddr_b = 5'd7;
    @(negedge clk); iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = $urandom;
    @(negedge clk); alu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7; #1;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin errors++; $display("FAIL setwins_write got wen=%b addr=%0d exp 1/7", rf_wen, rf_waddr); end
    @(negedge clk); iss_valid = 1'b0; #1;
    checks++; if (busy_b !== 1'b1 || rf_wen !== 1'b0) begin errors++; $display("FAIL setwins_busy got busy=%b wen=%b exp 1/0", busy_b, rf_wen); end
    idle();
  endtask

  task automatic test_bypass();
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd5; raddr_a = 5'd5; raddr_b = 5'd6;
    @(negedge clk); iss_valid = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'hCAFE; #1;
    checks++; if (lsu_ready !== 1'b1 || busy_a !== 1'b1) begin errors++; $display("FAIL byp_issue got ready=%b busy=%b exp 1/1", lsu_ready, busy_a); end
    @(negedge clk); lsu_valid = 1'b0; #1;
    checks++; if (rf_wen !== 1'b1 || fwd_a_valid !== BYP || busy_a !== !BYP) begin errors++; $display("FAIL byp_hit got wen=%b fwd=%b busy=%b exp 1/%b/%b", rf_wen, fwd_a_valid, busy_a, BYP, !BYP); end
    checks++; if (fwd_a_data !== (BYP ? 32'hCAFE : 32'h0)) begin errors++; $display("FAIL byp_data got %h exp %h", fwd_a_data, BYP ? 32'hCAFE : 32'h0); end
    checks++; if (fwd_b_valid !== 1'b0) begin errors++; $display("FAIL byp_miss_b got %b exp 0", fwd_b_valid); end
    @(negedge clk); #1;
    checks++; if (busy_a !== 1'b0 || fwd_a_valid !== 1'b0) begin errors++; $display("FAIL byp_after got busy=%b fwd=%b exp 0/0", busy_a, fwd_a_valid); end
    idle();
  endtask

  // Reference model: architectural view of the scoreboard and the write stage.
  task automatic test_random();
    bit            m_pend [RN];
    bit            m_wen, m_pref_lsu, alu_hold, lsu_hold;
    logic [RB-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            e_alu, e_lsu, e_hit_a, e_hit_b, e_busy_a, e_busy_b;
    logic [DW-1:0] e_fdata;
    alu_hold = 1'b0; lsu_hold = 1'b0;
    @(negedge clk); rst = 1'b1; idle();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_pref_lsu = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if (!alu_hold) begin alu_valid = ($urandom_range(0, 2) != 0); alu_rd = RB'($urandom_range(0, RN - 1)); alu_data = $urandom; end
      if (!lsu_hold) begin lsu_valid = ($urandom_range(0, 2) != 0); lsu_rd = RB'($urandom_range(0, RN - 1)); lsu_data = $urandom; end
      iss_rd    = RB'($urandom_range(0, RN - 1));
      iss_valid = ($urandom_range(0, 2) == 0) && !m_pend[iss_rd];
      raddr_a   = ($urandom_range(0, 2) == 0) ? m_waddr : RB'($urandom_range(0, RN - 1));
      raddr_b   = ($urandom_range(0, 2) == 0) ? m_waddr : RB'($urandom_range(0, RN - 1));
      #1;
      e_lsu    = !rst && lsu_valid && (!alu_valid || m_pref_lsu);
      e_alu    = !rst && alu_valid && !e_lsu;
      e_hit_a  = BYP && m_wen && (m_waddr == raddr_a) && (raddr_a != 0);
      e_hit_b  = BYP && m_wen && (m_waddr == raddr_b) && (raddr_b != 0);
      e_busy_a = (raddr_a != 0) && m_pend[raddr_a] && !e_hit_a;
      e_busy_b = (raddr_b != 0) && m_pend[raddr_b] && !e_hit_b;
      e_fdata  = BYP ? m_wdata : '0;
      checks++; if (alu_ready !== e_alu || lsu_ready !== e_lsu) begin errors++; $display("FAIL rnd_grant c%0d got alu=%b lsu=%b exp %b/%b", cyc, alu_ready, lsu_ready, e_alu, e_lsu); end
      checks++; if (rf_wen !== m_wen) begin errors++; $display("FAIL rnd_wen c%0d got %b exp %b", cyc, rf_wen, m_wen); end
      checks++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wport c%0d got %0d/%h exp %0d/%h", cyc, rf_waddr, rf_wdata, m_waddr, m_wdata); end
      checks++; if (busy_a !== e_busy_a || busy_b !== e_busy_b) begin errors++; $display("FAIL rnd_busy c%0d got %b%b exp %b%b", cyc, busy_a, busy_b, e_busy_a, e_busy_b); end
      checks++; if (fwd_a_valid !== e_hit_a || fwd_b_valid !== e_hit_b) begin errors++; $display("FAIL rnd_fwd c%0d got %b%b exp %b%b", cyc, fwd_a_valid, fwd_b_valid, e_hit_a, e_hit_b); end
      checks++; if (fwd_a_data !== e_fdata || fwd_b_data !== e_fdata) begin errors++; $display("FAIL rnd_fdata c%0d got %h/%h exp %h", cyc, fwd_a_data, fwd_b_data, e_fdata); end
      alu_hold = alu_valid && !e_alu;
      lsu_hold = lsu_valid && !e_lsu;
      if (rst) begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_pref_lsu = 1'b1;
      end else begin
        if (m_wen) m_pend[m_waddr] = 1'b0;
        if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
        if (alu_valid && lsu_valid) m_pref_lsu = e_alu;
        m_wen = 1'b0;
        if (e_lsu) begin m_wen = (lsu_rd != 0); m_waddr = lsu_rd; m_wdata = lsu_data; end
        if (e_alu) begin m_wen = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data; end
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_round_robin();
    test_rd_zero();
    test_set_wins();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
